// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle controller: state encodings,
// opcode constants, datapath select encodings and the per-state output table.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR_WB  = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_I_ALU  = 7'd19;
    localparam logic [6:0] OP_LW     = 7'd3;
    localparam logic [6:0] OP_SW     = 7'd35;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_JALR   = 7'd103;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_sel_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'b00,
        SRC_A_OLD_PC = 2'b01,
        SRC_A_RS1    = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } src_b_t;

    typedef enum logic [1:0] {
        RES_ALU_OUT    = 2'b00,
        RES_LOAD_DATA  = 2'b01,
        RES_ALU_RESULT = 2'b10
    } res_sel_t;

    // Moore part of the control word; the is_* flags let the top qualify
    // the ready-dependent strobes without re-decoding the state.
    typedef struct packed {
        alu_op_t  alu_op;
        src_a_t   src_a;
        src_b_t   src_b;
        res_sel_t res_sel;
        logic     adr_src;
        logic     mem_req;
        logic     mem_write;
        logic     reg_write;
        logic     branch;
        logic     pc_update;
        logic     instr_done;
        logic     is_fetch;
        logic     is_decode;
        logic     is_memwrite;
        logic     is_trap;
    } ctl_t;

    function automatic logic is_legal_op(logic [6:0] op);
        case (op)
            OP_R, OP_I_ALU, OP_LW, OP_SW, OP_BRANCH, OP_JAL, OP_JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Control word driven while the FSM sits in state s.
    function automatic ctl_t state_outputs(state_t s);
        ctl_t c;
        // NOTE: start from an all-zero word so every field has a value on
        // every path; a missing default is how combinational latches appear.
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req  = 1'b1;
                c.src_b    = SRC_B_FOUR;
                c.res_sel  = RES_ALU_RESULT;
                c.is_fetch = 1'b1;
            end
            S_DECODE: begin
                c.src_a     = SRC_A_OLD_PC;
                c.src_b     = SRC_B_IMM;
                c.is_decode = 1'b1;
            end
            S_MEMADR: begin
                c.src_a = SRC_A_RS1;
                c.src_b = SRC_B_IMM;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.res_sel    = RES_LOAD_DATA;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req     = 1'b1;
                c.adr_src     = 1'b1;
                c.mem_write   = 1'b1;
                c.is_memwrite = 1'b1;
            end
            S_EXEC_R: begin
                c.src_a  = SRC_A_RS1;
                c.alu_op = ALU_FUNCT;
            end
            S_EXEC_I: begin
                c.src_a  = SRC_A_RS1;
                c.src_b  = SRC_B_IMM;
                c.alu_op = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.src_a      = SRC_A_RS1;
                c.alu_op     = ALU_BRANCH;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JAL: begin
                c.src_a     = SRC_A_OLD_PC;
                c.src_b     = SRC_B_FOUR;
                c.pc_update = 1'b1;
            end
            S_JALR: begin
                c.src_a     = SRC_A_RS1;
                c.src_b     = SRC_B_IMM;
                c.res_sel   = RES_ALU_RESULT;
                c.pc_update = 1'b1;
            end
            S_JALR_WB: begin
                c.src_a      = SRC_A_OLD_PC;
                c.src_b      = SRC_B_FOUR;
                c.res_sel    = RES_ALU_RESULT;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_TRAP: begin
                c.is_trap = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the
// datapath/memory side (slave).
interface multicycle_controller_if;

    logic [6:0] op;
    logic       mem_ready;
    logic [1:0] ALUOp;
    logic [1:0] ext_imm_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] res_sel;
    logic       adr_src;
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       pc_update;
    logic       reg_write;
    logic       branch;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state_o;

    modport master (
        input  op, mem_ready,
        output ALUOp, ext_imm_sel, alu_src_a, alu_src_b, res_sel, adr_src,
               mem_req, mem_write, ir_write, pc_update, reg_write, branch,
               instr_done, illegal, state_o
    );

    modport slave (
        output op, mem_ready,
        input  ALUOp, ext_imm_sel, alu_src_a, alu_src_b, res_sel, adr_src,
               mem_req, mem_write, ir_write, pc_update, reg_write, branch,
               instr_done, illegal, state_o
    );

endinterface

// File: rtl/imm_sel_decoder.sv
// Immediate-format select, decoded straight from the opcode in every state.
module imm_sel_decoder
    import multicycle_pkg::*;
(
    input  logic [6:0] op,
    output imm_sel_t   imm_sel
);

    // Map opcode to immediate format; anything unlisted falls back to I.
    always_comb begin
        case (op)
            OP_SW:     imm_sel = IMM_S;
            OP_BRANCH: imm_sel = IMM_B;
            OP_JAL:    imm_sel = IMM_J;
            default:   imm_sel = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM. State and the Moore control word are
// registered together; only the ready-qualified strobes, the TRAP_EN=0
// illegal pulse and ext_imm_sel are combinational.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit TRAP_EN       = 1'b1
)
(
    input  logic                     clk,
    input  logic                     rst,
    multicycle_controller_if.master  bus
);

    logic     ready;
    state_t   state_q;
    state_t   state_d;
    ctl_t     ctl_q;
    imm_sel_t imm_sel;

    assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    function automatic state_t next_state(state_t s, logic [6:0] op, logic rdy);
        case (s)
            S_FETCH:    return rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: return S_MEMADR;
                    OP_R:         return S_EXEC_R;
                    OP_I_ALU:     return S_EXEC_I;
                    OP_BRANCH:    return S_BRANCH;
                    OP_JAL:       return S_JAL;
                    OP_JALR:      return S_JALR;
                    default:      return TRAP_EN ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:   return (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  return rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    return S_FETCH;
            S_MEMWRITE: return rdy ? S_FETCH : S_MEMWRITE;
            S_EXEC_R:   return S_ALUWB;
            S_EXEC_I:   return S_ALUWB;
            S_ALUWB:    return S_FETCH;
            S_BRANCH:   return S_FETCH;
            S_JAL:      return S_ALUWB;
            S_JALR:     return S_JALR_WB;
            S_JALR_WB:  return S_FETCH;
            S_TRAP:     return S_TRAP;
            default:    return S_FETCH;
        endcase
    endfunction

    assign state_d = next_state(state_q, bus.op, ready);

    // State register plus the control word for the state being entered;
    // reset wins over any pending transition, including a wait or TRAP.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctl_q   <= state_outputs(S_FETCH);
        end else begin
            state_q <= state_d;
            ctl_q   <= state_outputs(state_d);
        end
    end

    imm_sel_decoder u_imm_sel_decoder (
        .op      (bus.op),
        .imm_sel (imm_sel)
    );

    assign bus.ALUOp       = ctl_q.alu_op;
    assign bus.ext_imm_sel = imm_sel;
    assign bus.alu_src_a   = ctl_q.src_a;
    assign bus.alu_src_b   = ctl_q.src_b;
    assign bus.res_sel     = ctl_q.res_sel;
    assign bus.adr_src     = ctl_q.adr_src;
    assign bus.mem_req     = ctl_q.mem_req;
    assign bus.mem_write   = ctl_q.mem_write;
    assign bus.reg_write   = ctl_q.reg_write;
    assign bus.branch      = ctl_q.branch;
    assign bus.state_o     = state_q;

    // Fetch completion and store completion only fire once memory answers.
    assign bus.ir_write    = ctl_q.is_fetch & ready;
    assign bus.pc_update   = ctl_q.pc_update | (ctl_q.is_fetch & ready);
    assign bus.instr_done  = ctl_q.instr_done | (ctl_q.is_memwrite & ready);

    // Sticky in TRAP; without trapping, a one-cycle flag while DECODE sees it.
    assign bus.illegal     = ctl_q.is_trap
                           | (!TRAP_EN & ctl_q.is_decode & !is_legal_op(bus.op));

endmodule
